// File: rtl/data_memory_lat.sv
// Byte-addressed 32-bit data memory with a fixed access latency, req/done handshake,
// byte/half/word accesses with sign/zero-extended loads and illegal-access reporting.
module data_memory_lat #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    bad_q, bad_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [7:0]              mem [DEPTH];

  logic                    accept_s;
  logic                    complete_s;
  logic                    illegal_s;
  logic [31:0]             word_s;
  logic [15:0]             sh_s;
  logic [31:0]             load_s;
  logic [3:0]              be_s;
  logic [31:0]             wlane_s;

  // The completing edge may also accept, so back-to-back accesses run every LATENCY cycles.
  assign ready_o    = (state_q == IDLE) || (cnt_q == 8'd0);
  assign accept_s   = req_i && ready_o;
  assign complete_s = (state_q == BUSY) && (cnt_q == 8'd0);

  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

  always_comb begin
    illegal_s = 1'b0;
    if ((addr_i >> ADDR_WIDTH) != 32'd0) begin
      illegal_s = 1'b1;
    end else begin
      case (size_i)
        2'b00:   illegal_s = 1'b0;
        2'b01:   illegal_s = addr_i[0];
        2'b10:   illegal_s = |addr_i[1:0];
        default: illegal_s = 1'b1;
      endcase
    end
  end

  // Read the whole aligned word, then pick the addressed lane(s).
  assign word_s = {mem[{addr_q[ADDR_WIDTH-1:2], 2'd3}], mem[{addr_q[ADDR_WIDTH-1:2], 2'd2}],
                   mem[{addr_q[ADDR_WIDTH-1:2], 2'd1}], mem[{addr_q[ADDR_WIDTH-1:2], 2'd0}]};
  assign sh_s   = 16'(word_s >> {addr_q[1:0], 3'b000});

  always_comb begin
    load_s  = 32'd0;
    be_s    = 4'b0000;
    wlane_s = wdata_q;
    case (size_q)
      2'b00: begin
        load_s  = uns_q ? {24'd0, sh_s[7:0]} : {{24{sh_s[7]}}, sh_s[7:0]};
        be_s    = 4'b0001 << addr_q[1:0];
        wlane_s = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_s  = uns_q ? {16'd0, sh_s} : {{16{sh_s[15]}}, sh_s};
        be_s    = 4'b0011 << {addr_q[1], 1'b0};
        wlane_s = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        load_s  = word_s;
        be_s    = 4'b1111;
        wlane_s = wdata_q;
      end
      default: begin
        load_s  = 32'd0;
        be_s    = 4'b0000;
        wlane_s = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (complete_s) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = bad_q;
      if (bad_q) begin
        rdata_d = 32'd0;
      end else if (!we_q) begin
        rdata_d = load_s;
      end else begin
        rdata_d = rdata_q;
      end
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    if (accept_s) begin
      state_d = BUSY;
      cnt_d   = CNT_LOAD;
      we_d    = we_i;
      size_d  = size_i;
      uns_d   = unsigned_i;
      addr_d  = addr_i[ADDR_WIDTH-1:0];
      wdata_d = wdata_i;
      bad_d   = illegal_s;
    end else begin
      bad_d = bad_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately not reset; a reset drops the pending store via state_q.
  always_ff @(posedge clk_i) begin
    if (complete_s && we_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[{addr_q[ADDR_WIDTH-1:2], 2'(i)}] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

endmodule
